// File: rtl/uc_multiciclo_if.sv
`default_nettype none
// ============================================================================
//  Module      : uc_multiciclo_if
//  Description : Handshake and control bus between the multicycle control
//                unit and the microc datapath / top level.
//                master modport : control unit side (drives the control lines)
//                slave  modport : datapath / top-level side
//  Signals     : start, Opcode[OPW-1:0], z                -> control unit
//                pc_en, s_inc, s_inm, we3, wez,
//                Op[ALUOPW-1:0], busy, illegal             <- control unit
//  Revision    : 1.0 - initial release
// ============================================================================
interface uc_multiciclo_if #(
   parameter int OPW    = 6,
   parameter int ALUOPW = 3
);
   logic              start;
   logic [OPW-1:0]    Opcode;
   logic              z;
   logic              pc_en;
   logic              s_inc;
   logic              s_inm;
   logic              we3;
   logic              wez;
   logic [ALUOPW-1:0] Op;
   logic              busy;
   logic              illegal;

   modport master (
      input  start, Opcode, z,
      output pc_en, s_inc, s_inm, we3, wez, Op, busy, illegal
   );

   modport slave (
      output start, Opcode, z,
      input  pc_en, s_inc, s_inm, we3, wez, Op, busy, illegal
   );
endinterface
`default_nettype wire

// File: rtl/uc_multiciclo.sv
`default_nettype none
// ============================================================================
//  Module      : uc_multiciclo
//  Description : Multicycle control unit for the microc datapath. Every
//                instruction takes two cycles: FETCH latches the opcode into
//                the instruction register, EXEC drives the datapath controls
//                for one cycle. An undefined opcode parks the unit in HALT
//                with a sticky illegal flag until reset.
//  Ports       : clk      - system clock, rising edge
//                reset    - synchronous reset, active-high
//                bus      - uc_multiciclo_if.master (start/Opcode/z in,
//                           pc_en/s_inc/s_inm/we3/wez/Op/busy/illegal out)
//                instr_cnt- (only with UC_PERF_CNT_EN) saturating count of
//                           EXEC cycles
//  Config      : UC_PERF_CNT_EN - adds the instr_cnt performance counter
//  Revision    : 1.0 - initial release
// ============================================================================
module uc_multiciclo #(
   parameter int OPW    = 6,
   parameter int ALUOPW = 3
) (
   input  wire logic          clk,
   input  wire logic          reset,
   uc_multiciclo_if.master    bus
`ifdef UC_PERF_CNT_EN
   ,
   output logic [15:0]        instr_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_FETCH = 2'b01,
      ST_EXEC  = 2'b10,
      ST_HALT  = 2'b11
   } state_t;

   localparam logic [OPW-1:0] c_OP_NOP = 6'b000000;
   localparam logic [OPW-1:0] c_OP_J   = 6'b010000;
   localparam logic [OPW-1:0] c_OP_JZ  = 6'b010001;
   localparam logic [OPW-1:0] c_OP_JNZ = 6'b010010;

   state_t         r_state;
   state_t         w_next_state;
   logic [OPW-1:0] r_ir;
   logic           r_illegal;
   logic           w_legal;

   // Legality is judged on the opcode being fetched so the decision to go
   // to EXEC or HALT is made in the same cycle the IR is loaded.
   always_comb begin
      w_legal = 1'b0;
      if (bus.Opcode[OPW-1])
         w_legal = 1'b1;                               // ALU
      else if (bus.Opcode[OPW-1:2] == 4'b0001)
         w_legal = 1'b1;                               // LI
      else if ((bus.Opcode == c_OP_NOP) || (bus.Opcode == c_OP_J) ||
               (bus.Opcode == c_OP_JZ)  || (bus.Opcode == c_OP_JNZ))
         w_legal = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_ir      <= '0;
         r_illegal <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (r_state == ST_FETCH) begin
            r_ir <= bus.Opcode;
            if (!w_legal)
               r_illegal <= 1'b1;
         end
      end
   end

   // Next state and Moore outputs; z only affects s_inc for JZ/JNZ.
   always_comb begin
      w_next_state = r_state;
      bus.pc_en    = 1'b0;
      bus.s_inc    = 1'b0;
      bus.s_inm    = 1'b0;
      bus.we3      = 1'b0;
      bus.wez      = 1'b0;
      bus.Op       = '0;
      bus.busy     = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (bus.start)
               w_next_state = ST_FETCH;
         end
         ST_FETCH: begin
            bus.busy     = 1'b1;
            w_next_state = w_legal ? ST_EXEC : ST_HALT;
         end
         ST_EXEC: begin
            bus.busy     = 1'b1;
            bus.pc_en    = 1'b1;
            w_next_state = ST_FETCH;
            if (r_ir[OPW-1]) begin
               bus.s_inc = 1'b1;
               bus.we3   = 1'b1;
               bus.wez   = 1'b1;
               bus.Op    = r_ir[ALUOPW-1:0];
            end else if (r_ir[OPW-1:2] == 4'b0001) begin
               bus.s_inc = 1'b1;
               bus.s_inm = 1'b1;
               bus.we3   = 1'b1;
            end else if (r_ir == c_OP_NOP) begin
               bus.s_inc = 1'b1;
            end else if (r_ir == c_OP_JZ) begin
               bus.s_inc = ~bus.z;
            end else if (r_ir == c_OP_JNZ) begin
               bus.s_inc = bus.z;
            end
            // J and anything else leave s_inc=0 (jump target); illegal
            // opcodes never reach EXEC.
         end
         default: begin
            w_next_state = ST_HALT;                    // HALT: only reset exits
         end
      endcase
   end

   assign bus.illegal = r_illegal;

`ifdef UC_PERF_CNT_EN
   logic [15:0] r_instr_cnt;

   always_ff @(posedge clk) begin
      if (reset)
         r_instr_cnt <= '0;
      else if ((r_state == ST_EXEC) && (r_instr_cnt != 16'hFFFF))
         r_instr_cnt <= r_instr_cnt + 16'd1;
   end

   assign instr_cnt = r_instr_cnt;
`endif

endmodule
`default_nettype wire
